// File: rtl/pmp_pkg.sv
// pmp_pkg: shared types, constants and helpers for the PMP scan checker.
// Holds the address-mode encoding, privilege codes, cfg/access bit
// positions, the checker state encoding and the permission helper.
package pmp_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } AdrMode_t;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_U = 2'b00;

  // Access type is one-hot {X,W,R}
  localparam int ACC_R = 0;
  localparam int ACC_W = 1;
  localparam int ACC_X = 2;

  // pmpcfg byte layout
  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  // Every requested access kind must be granted by the entry's R/W/X bits.
  function automatic logic access_ok(input logic [2:0] perms, input logic [2:0] acc);
    return (!acc[ACC_R] || perms[CFG_R]) &&
           (!acc[ACC_W] || perms[CFG_W]) &&
           (!acc[ACC_X] || perms[CFG_X]);
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// pmp_entry_match: combinational match of one access against one PMP entry.
// Regions are word-granular, so an access of up to 8 naturally aligned
// bytes touches at most two words: lo_word and hi_word (equal unless Size=3).
// Match means any touched word is inside the region; AllBytesMatch means
// every touched word is inside it.
module pmp_entry_match #(
  parameter int PA_BITS = 56
) (
  input  logic [PA_BITS-1:0] PA,
  input  logic [1:0]         Size,
  input  logic [7:0]         Cfg,
  input  logic [PA_BITS-3:0] Adr,
  input  logic [PA_BITS-3:0] PrevAdr,
  output logic               Match,
  output logic               AllBytesMatch
);
  import pmp_pkg::*;

  localparam int AW = PA_BITS - 2;

  logic [AW-1:0] lo_word_s;
  logic [AW-1:0] hi_word_s;
  logic [AW-1:0] napot_care_s;
  logic          lo_in_s;
  logic          hi_in_s;
  logic          unused_bits_s;

  // Byte offset inside the word and the lock/reserved cfg bits do not affect region membership
  assign unused_bits_s = ^{PA[1:0], Cfg[7:5], Cfg[2:0]};

  // Region membership of the first and last touched word, by address mode
  always_comb begin
    lo_word_s = PA[PA_BITS-1:2];
    if (Size == 2'd3) begin
      hi_word_s = {lo_word_s[AW-1:1], 1'b1};
    end else begin
      hi_word_s = lo_word_s;
    end
    // Trailing ones plus the next bit are don't-care positions of a NAPOT region
    napot_care_s = ~(Adr ^ (Adr + AW'(1)));
    case (AdrMode_t'(Cfg[CFG_A_HI:CFG_A_LO]))
      TOR: begin
        lo_in_s = (lo_word_s >= PrevAdr) && (lo_word_s < Adr);
        hi_in_s = (hi_word_s >= PrevAdr) && (hi_word_s < Adr);
      end
      NA4: begin
        lo_in_s = (lo_word_s == Adr);
        hi_in_s = (hi_word_s == Adr);
      end
      NAPOT: begin
        lo_in_s = ((lo_word_s ^ Adr) & napot_care_s) == {AW{1'b0}};
        hi_in_s = ((hi_word_s ^ Adr) & napot_care_s) == {AW{1'b0}};
      end
      default: begin
        lo_in_s = 1'b0;
        hi_in_s = 1'b0;
      end
    endcase
    Match         = lo_in_s | hi_in_s;
    AllBytesMatch = lo_in_s & hi_in_s;
  end

endmodule

// File: rtl/pmp_scan_checker.sv
// pmp_scan_checker: multi-cycle PMP checker, LANES entries per beat.
// One access in flight; lowest-numbered matching entry wins and the
// permit/fault result is returned through a registered valid/ready port.
// Build option: define PMP_HITCACHE_EN to add a one-entry result cache
// that answers a repeated request without scanning.
module pmp_scan_checker #(
  parameter  int PA_BITS     = 56,
  parameter  int PMP_ENTRIES = 16,
  parameter  int LANES       = 4,
  localparam int IDX_W       = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                ReqValid,
  output logic                                ReqReady,
  input  logic [PA_BITS-1:0]                  PhysicalAddress,
  input  logic [1:0]                          Size,
  input  logic [1:0]                          PrivMode,
  input  logic [2:0]                          AccessType,
  input  logic [8*PMP_ENTRIES-1:0]            PMPCfg,
  input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0]  PMPAdr,
  input  logic                                PMPUpdate,
  output logic                                RspValid,
  input  logic                                RspReady,
  output logic                                RspFault,
  output logic                                RspMatched,
  output logic [IDX_W-1:0]                    RspIdx
);
  import pmp_pkg::*;

  localparam int AW     = PA_BITS - 2;
  localparam int NBEATS = PMP_ENTRIES / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t              state_r;
  logic [BEAT_W-1:0]   beat_r;
  logic [PA_BITS-1:0]  pa_r;
  logic [1:0]          size_r;
  logic [1:0]          priv_r;
  logic [2:0]          acc_r;

  int                  lane_base_s;
  logic [7:0]          lane_cfg_s   [LANES];
  logic [AW-1:0]       lane_adr_s   [LANES];
  logic [AW-1:0]       lane_prev_s  [LANES];
  logic                lane_match_s [LANES];
  logic                lane_all_s   [LANES];

  logic                hit_s;
  logic [LANE_W-1:0]   hit_lane_s;
  logic                win_all_s;
  logic [2:0]          win_perm_s;
  logic                win_lock_s;
  logic                perm_ok_s;
  logic                res_fault_s;
  logic                res_matched_s;
  logic [IDX_W-1:0]    res_idx_s;
  logic                last_beat_s;
  logic                scan_done_s;

  logic                cache_hit_s;
  logic                cache_fault_s;
  logic                cache_matched_s;
  logic [IDX_W-1:0]    cache_idx_s;

  // Route the entries of the current beat (and their TOR lower bounds) to the lanes
  always_comb begin
    lane_base_s = int'(beat_r) * LANES;
    for (int l = 0; l < LANES; l++) begin
      lane_cfg_s[l] = PMPCfg[8*(lane_base_s+l) +: 8];
      lane_adr_s[l] = PMPAdr[AW*(lane_base_s+l) +: AW];
      if (lane_base_s + l == 0) begin
        lane_prev_s[l] = {AW{1'b0}};
      end else begin
        lane_prev_s[l] = PMPAdr[AW*(lane_base_s+l-1) +: AW];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pmp_entry_match #(
      .PA_BITS (PA_BITS)
    ) u_match (
      .PA            (pa_r),
      .Size          (size_r),
      .Cfg           (lane_cfg_s[l]),
      .Adr           (lane_adr_s[l]),
      .PrevAdr       (lane_prev_s[l]),
      .Match         (lane_match_s[l]),
      .AllBytesMatch (lane_all_s[l])
    );
  end

  // Lowest matching lane wins; derive permit/fault for this beat
  always_comb begin
    hit_s      = 1'b0;
    hit_lane_s = {LANE_W{1'b0}};
    for (int l = LANES - 1; l >= 0; l--) begin
      hit_s      = hit_s | lane_match_s[l];
      hit_lane_s = lane_match_s[l] ? LANE_W'(l) : hit_lane_s;
    end
    win_all_s     = lane_all_s[hit_lane_s];
    win_perm_s    = lane_cfg_s[hit_lane_s][2:0];
    win_lock_s    = lane_cfg_s[hit_lane_s][CFG_L];
    perm_ok_s     = access_ok(win_perm_s, acc_r);
    res_matched_s = hit_s;
    res_idx_s     = hit_s ? IDX_W'(lane_base_s + int'(hit_lane_s)) : {IDX_W{1'b0}};
    if (!hit_s) begin
      res_fault_s = (priv_r != PRIV_M);
    end else if (!win_all_s) begin
      // A partially covered access faults whatever the permissions say
      res_fault_s = 1'b1;
    end else if (priv_r == PRIV_M) begin
      res_fault_s = win_lock_s & ~perm_ok_s;
    end else begin
      res_fault_s = ~perm_ok_s;
    end
  end

  assign last_beat_s = (beat_r == BEAT_W'(NBEATS - 1));
  // A CSR write during the scan forces a restart, so this beat's result is dropped
  assign scan_done_s = (state_r == SCAN) && !PMPUpdate && (hit_s || last_beat_s);

`ifdef PMP_HITCACHE_EN
  localparam int KEY_W = AW + 2 + 2 + 3;

  logic              cache_valid_r;
  logic [KEY_W-1:0]  cache_key_r;
  logic              cache_fault_r;
  logic              cache_matched_r;
  logic [IDX_W-1:0]  cache_idx_r;
  logic [KEY_W-1:0]  req_key_s;

  assign req_key_s       = {PhysicalAddress[PA_BITS-1:2], Size, PrivMode, AccessType};
  // Same-cycle CSR write makes the lookup miss
  assign cache_hit_s     = cache_valid_r && (cache_key_r == req_key_s) && !PMPUpdate;
  assign cache_fault_s   = cache_fault_r;
  assign cache_matched_s = cache_matched_r;
  assign cache_idx_s     = cache_idx_r;

  // One-entry result cache: filled when a scan completes, dropped on any CSR write
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_r   <= 1'b0;
      cache_key_r     <= {KEY_W{1'b0}};
      cache_fault_r   <= 1'b0;
      cache_matched_r <= 1'b0;
      cache_idx_r     <= {IDX_W{1'b0}};
    end else if (PMPUpdate) begin
      cache_valid_r   <= 1'b0;
    end else if (scan_done_s) begin
      cache_valid_r   <= 1'b1;
      cache_key_r     <= {pa_r[PA_BITS-1:2], size_r, priv_r, acc_r};
      cache_fault_r   <= res_fault_s;
      cache_matched_r <= res_matched_s;
      cache_idx_r     <= res_idx_s;
    end
  end
`else
  assign cache_hit_s     = 1'b0;
  assign cache_fault_s   = 1'b0;
  assign cache_matched_s = 1'b0;
  assign cache_idx_s     = {IDX_W{1'b0}};
`endif

  // Request/scan/response FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      beat_r     <= {BEAT_W{1'b0}};
      pa_r       <= {PA_BITS{1'b0}};
      size_r     <= 2'b00;
      priv_r     <= 2'b00;
      acc_r      <= 3'b000;
      ReqReady   <= 1'b1;
      RspValid   <= 1'b0;
      RspFault   <= 1'b0;
      RspMatched <= 1'b0;
      RspIdx     <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (ReqValid) begin
            pa_r     <= PhysicalAddress;
            size_r   <= Size;
            priv_r   <= PrivMode;
            acc_r    <= AccessType;
            beat_r   <= {BEAT_W{1'b0}};
            ReqReady <= 1'b0;
            if (cache_hit_s) begin
              state_r    <= DONE;
              RspValid   <= 1'b1;
              RspFault   <= cache_fault_s;
              RspMatched <= cache_matched_s;
              RspIdx     <= cache_idx_s;
            end else begin
              state_r <= SCAN;
            end
          end
        end
        SCAN: begin
          if (PMPUpdate) begin
            beat_r <= {BEAT_W{1'b0}};
          end else if (scan_done_s) begin
            state_r    <= DONE;
            RspValid   <= 1'b1;
            RspFault   <= res_fault_s;
            RspMatched <= res_matched_s;
            RspIdx     <= res_idx_s;
          end else begin
            beat_r <= beat_r + BEAT_W'(1);
          end
        end
        DONE: begin
          if (RspReady) begin
            state_r  <= IDLE;
            RspValid <= 1'b0;
            ReqReady <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          RspValid <= 1'b0;
          ReqReady <= 1'b1;
        end
      endcase
    end
  end

endmodule
